// File: rtl/pool_engine_param.sv
// Max/average pooling engine: reduces K-wide or KxK windows of N-lane words
// and packs K successive group results into one output word.
module pool_engine_param #(
    parameter int N_LANES = 16,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      cfg_2d,
    input  logic [1:0]                cfg_k_log2,
    input  logic                      cfg_avg,
    input  logic [ADDR_W-1:0]         cfg_rd_base,
    input  logic [CNT_W-1:0]          cfg_row_stride,
    input  logic [CNT_W-1:0]          cfg_words_per_row,
    input  logic [CNT_W-1:0]          cfg_num_out,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [N_LANES*DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0]         cfg_wr_base,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [N_LANES*DATA_W-1:0] wr_data,
    output logic                      busy,
    output logic                      done
);
    localparam int SW = DATA_W + 4;
    localparam int GM = N_LANES / 2;
    localparam int WW = N_LANES * DATA_W;

    typedef enum logic [2:0] {IDLE, ISSUE, ACCUM, WRITE, DONE} state_t;

    state_t state_q, state_d;

    logic              two_d_q, k4_q, avg_q;
    logic [ADDR_W-1:0] stride_q, wbase_q, row_base_q;
    logic [CNT_W-1:0]  wpr_q, nout_q, x_q, out_cnt_q;
    logic [1:0]        r_q, s_q;
    logic [WW-1:0]     pack_q, pack_d, wr_data_q;

    logic signed [SW-1:0] acc_q [GM];
    logic signed [SW-1:0] acc_d [GM];
    logic [DATA_W-1:0]    res [GM];

    logic [1:0]        kmax;
    logic [2:0]        shamt;
    logic              last_r, last_s, row_end;
    logic [ADDR_W-1:0] r_off, row_step;

    function automatic logic signed [SW-1:0] lane(
        input logic [WW-1:0] w,
        input int            i
    );
        return SW'(signed'(w[i*DATA_W +: DATA_W]));
    endfunction

    function automatic logic signed [SW-1:0] smax(
        input logic signed [SW-1:0] a,
        input logic signed [SW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // One window's contribution from the current word: sum or max of K lanes
    function automatic logic signed [SW-1:0] window(
        input logic [WW-1:0] w,
        input int            g,
        input logic          k4,
        input logic          avg
    );
        int b;
        logic signed [SW-1:0] e0, e1, e2, e3, sum, mx;
        b   = k4 ? (4 * g) % N_LANES : 2 * g;
        e0  = lane(w, b);
        e1  = lane(w, b + 1);
        e2  = lane(w, (b + 2) % N_LANES);
        e3  = lane(w, (b + 3) % N_LANES);
        sum = k4 ? e0 + e1 + e2 + e3 : e0 + e1;
        mx  = k4 ? smax(smax(e0, e1), smax(e2, e3)) : smax(e0, e1);
        return avg ? sum : mx;
    endfunction

    assign kmax    = k4_q ? 2'd3 : 2'd1;
    assign last_r  = !two_d_q || (r_q == kmax);
    assign last_s  = (s_q == kmax);
    assign row_end = (x_q + CNT_W'(1)) == wpr_q;
    assign shamt   = two_d_q ? (k4_q ? 3'd4 : 3'd2) : (k4_q ? 3'd2 : 3'd1);

    always_comb begin
        r_off = '0;
        case (r_q)
            2'd1:    r_off = stride_q;
            2'd2:    r_off = stride_q << 1;
            2'd3:    r_off = stride_q + (stride_q << 1);
            default: r_off = '0;
        endcase
        row_step = stride_q;
        if (two_d_q)
            row_step = k4_q ? stride_q << 2 : stride_q << 1;
    end

    always_comb begin
        pack_d = pack_q;
        for (int g = 0; g < GM; g++) begin
            logic signed [SW-1:0] wv;
            int idx;
            wv = window(rd_data, g, k4_q, avg_q);
            if (r_q == 2'd0)
                acc_d[g] = wv;
            else
                acc_d[g] = avg_q ? acc_q[g] + wv : smax(acc_q[g], wv);
            res[g] = avg_q ? DATA_W'(acc_d[g] >>> shamt) : acc_d[g][DATA_W-1:0];
            idx = k4_q ? int'(s_q) * (N_LANES / 4) + g
                       : int'(s_q) * (N_LANES / 2) + g;
            if (!k4_q || g < N_LANES / 4)
                pack_d[idx*DATA_W +: DATA_W] = res[g];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   state_d = ACCUM;
            ACCUM:   state_d = (last_r && last_s) ? WRITE : ISSUE;
            WRITE:   state_d = (out_cnt_q + CNT_W'(1) == nout_q) ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            two_d_q    <= 1'b0;
            k4_q       <= 1'b0;
            avg_q      <= 1'b0;
            stride_q   <= '0;
            wbase_q    <= '0;
            row_base_q <= '0;
            wpr_q      <= '0;
            nout_q     <= '0;
            x_q        <= '0;
            out_cnt_q  <= '0;
            r_q        <= '0;
            s_q        <= '0;
            pack_q     <= '0;
            wr_data_q  <= '0;
            for (int g = 0; g < GM; g++) acc_q[g] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    two_d_q    <= cfg_2d;
                    k4_q       <= (cfg_k_log2 == 2'd2);
                    avg_q      <= cfg_avg;
                    stride_q   <= ADDR_W'(cfg_row_stride);
                    wbase_q    <= cfg_wr_base;
                    row_base_q <= cfg_rd_base;
                    wpr_q      <= cfg_words_per_row;
                    nout_q     <= cfg_num_out;
                    x_q        <= '0;
                    out_cnt_q  <= '0;
                    r_q        <= '0;
                    s_q        <= '0;
                end
                ISSUE: if (r_q == 2'd0) begin
                    for (int g = 0; g < GM; g++) acc_q[g] <= '0;
                end
                ACCUM: begin
                    for (int g = 0; g < GM; g++) acc_q[g] <= acc_d[g];
                    if (!last_r) begin
                        r_q <= r_q + 2'd1;
                    end else begin
                        pack_q <= pack_d;
                        r_q    <= '0;
                        if (row_end) begin
                            x_q        <= '0;
                            row_base_q <= row_base_q + row_step;
                        end else begin
                            x_q <= x_q + CNT_W'(1);
                        end
                        if (last_s) begin
                            s_q       <= '0;
                            wr_data_q <= pack_d;
                        end else begin
                            s_q <= s_q + 2'd1;
                        end
                    end
                end
                WRITE: out_cnt_q <= out_cnt_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign rd_en   = (state_q == ISSUE);
    assign rd_addr = rd_en ? row_base_q + ADDR_W'(x_q) + r_off : '0;
    assign wr_en   = (state_q == WRITE);
    assign wr_addr = wr_en ? wbase_q + ADDR_W'(out_cnt_q) : '0;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == ISSUE) || (state_q == ACCUM) || (state_q == WRITE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_pool_engine_param.sv
// Directed testbench for pool_engine_param with a behavioural activation
// memory and write/read logs; expected words are hand-derived per scenario.
module tb_pool_engine_param;
    localparam int N  = 16;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int CW = 16;
    localparam int W  = N * DW;

    logic          clk, reset, start;
    logic          cfg_2d, cfg_avg;
    logic [1:0]    cfg_k_log2;
    logic [AW-1:0] cfg_rd_base, cfg_wr_base;
    logic [CW-1:0] cfg_row_stride, cfg_words_per_row, cfg_num_out;
    logic          rd_en, wr_en, busy, done;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [W-1:0]  rd_data, wr_data;

    logic [W-1:0]  mem [256];
    logic [AW-1:0] rd_log [$];
    logic [AW-1:0] wa_log [$];
    logic [W-1:0]  wd_log [$];
    int done_cnt;
    int rd0, wa0, dn0;
    int vectors, miscompares;

    pool_engine_param #(
        .N_LANES(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_2d(cfg_2d), .cfg_k_log2(cfg_k_log2), .cfg_avg(cfg_avg),
        .cfg_rd_base(cfg_rd_base), .cfg_row_stride(cfg_row_stride),
        .cfg_words_per_row(cfg_words_per_row), .cfg_num_out(cfg_num_out),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .cfg_wr_base(cfg_wr_base), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial done_cnt = 0;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr[7:0]];
            rd_log.push_back(rd_addr);
        end
        if (wr_en) begin
            wa_log.push_back(wr_addr);
            wd_log.push_back(wr_data);
        end
        if (done) done_cnt = done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [AW-1:0] rd_at(input int i);
        return (rd0 + i < rd_log.size()) ? rd_log[rd0 + i] : 'x;
    endfunction

    function automatic logic [AW-1:0] wa_at(input int i);
        return (wa0 + i < wa_log.size()) ? wa_log[wa0 + i] : 'x;
    endfunction

    function automatic logic [W-1:0] wd_at(input int i);
        return (wa0 + i < wd_log.size()) ? wd_log[wa0 + i] : 'x;
    endfunction

    task automatic mark();
        rd0 = rd_log.size();
        wa0 = wa_log.size();
        dn0 = done_cnt;
    endtask

    task automatic fill_ramp(input int a, input int base);
        for (int l = 0; l < N; l++) mem[a][l*DW +: DW] = DW'(base + l);
    endtask

    task automatic fill_pair(input int a, input int v0, input int v1);
        for (int l = 0; l < N; l++)
            mem[a][l*DW +: DW] = DW'((l % 2 == 0) ? v0 : v1);
    endtask

    task automatic set_cfg(input bit d2, input int kl, input bit avg,
                           input int rb, input int st, input int wpr,
                           input int no, input int wb);
        cfg_2d            = d2;
        cfg_k_log2        = 2'(kl);
        cfg_avg           = avg;
        cfg_rd_base       = AW'(rb);
        cfg_row_stride    = CW'(st);
        cfg_words_per_row = CW'(wpr);
        cfg_num_out       = CW'(no);
        cfg_wr_base       = AW'(wb);
    endtask

    task automatic run(output bit ok, output int cyc);
        mark();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        cyc = 1;
        while (!done && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        ok = done;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 0;
        start = 0;
        set_cfg(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({rd_en, wr_en, busy, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000", {rd_en, wr_en, busy, done});
        end
        vectors++;
        if (rd_addr !== '0 || wr_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_addr: got rd=%h wr=%h expected 0", rd_addr, wr_addr);
        end
        vectors++;
        if (wr_data !== '0) begin
            miscompares++;
            $display("FAIL reset_wdata: got %h expected 0", wr_data);
        end
        @(negedge clk);
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b rd_en=%b expected 0 0", busy, rd_en);
        end
    endtask

    task automatic test_1d_max();
        bit ok;
        int cyc;
        logic [W-1:0] exp_w;
        for (int w = 0; w < 4; w++) fill_ramp(w, 16 * w);
        set_cfg(0, 2, 0, 0, 4, 4, 1, 'h40);
        run(ok, cyc);
        for (int s = 0; s < 4; s++)
            for (int g = 0; g < 4; g++)
                exp_w[(4*s+g)*DW +: DW] = DW'(16*s + 4*g + 3);
        vectors++;
        if (!ok || cyc != 10) begin
            miscompares++;
            $display("FAIL max1d_latency: got done=%0b cyc=%0d expected 1 10", ok, cyc);
        end
        vectors++;
        if (wa_log.size() - wa0 != 1 || wa_at(0) !== 16'h0040) begin
            miscompares++;
            $display("FAIL max1d_waddr: got n=%0d a=%h expected 1 0040", wa_log.size() - wa0, wa_at(0));
        end
        vectors++;
        if (wd_at(0) !== exp_w) begin
            miscompares++;
            $display("FAIL max1d_data: got %h expected %h", wd_at(0), exp_w);
        end
        vectors++;
        if (rd_log.size() - rd0 != 4 ||
            {rd_at(0), rd_at(1), rd_at(2), rd_at(3)} !== {16'd0, 16'd1, 16'd2, 16'd3}) begin
            miscompares++;
            $display("FAIL max1d_raddr: got %h %h %h %h expected 0 1 2 3",
                     rd_at(0), rd_at(1), rd_at(2), rd_at(3));
        end
        vectors++;
        if (done_cnt - dn0 != 1) begin
            miscompares++;
            $display("FAIL max1d_done: got %0d pulses expected 1", done_cnt - dn0);
        end
    endtask

    task automatic test_2d_avg();
        bit ok;
        int cyc;
        logic [W-1:0] exp_w;
        for (int w = 0; w < 4; w++) fill_ramp(w, 0);
        for (int w = 0; w < 8; w++)
            for (int l = 0; l < N; l++) mem[w][l*DW +: DW] = (w < 4) ? 8'd3 : 8'd4;
        set_cfg(1, 1, 1, 0, 4, 4, 1, 'h50);
        run(ok, cyc);
        exp_w = {N{8'd3}};
        vectors++;
        if (!ok || cyc != 10) begin
            miscompares++;
            $display("FAIL avg2d_latency: got done=%0b cyc=%0d expected 1 10", ok, cyc);
        end
        vectors++;
        if (rd_log.size() - rd0 != 4 ||
            {rd_at(0), rd_at(1), rd_at(2), rd_at(3)} !== {16'd0, 16'd4, 16'd1, 16'd5}) begin
            miscompares++;
            $display("FAIL avg2d_raddr: got %h %h %h %h expected 0 4 1 5",
                     rd_at(0), rd_at(1), rd_at(2), rd_at(3));
        end
        vectors++;
        if (wa_log.size() - wa0 != 1 || wa_at(0) !== 16'h0050 || wd_at(0) !== exp_w) begin
            miscompares++;
            $display("FAIL avg2d_data: got a=%h d=%h expected 0050 %h", wa_at(0), wd_at(0), exp_w);
        end
    endtask

    task automatic test_negatives();
        bit ok;
        int cyc;
        fill_pair(0, -3, -2);
        fill_pair(1, -128, -1);
        set_cfg(0, 1, 1, 0, 2, 2, 1, 'h60);
        run(ok, cyc);
        vectors++;
        if (!ok || cyc != 6) begin
            miscompares++;
            $display("FAIL neg_latency: got done=%0b cyc=%0d expected 1 6", ok, cyc);
        end
        vectors++;
        if (wd_at(0) !== {{8{8'hBF}}, {8{8'hFD}}}) begin
            miscompares++;
            $display("FAIL neg_avg: got %h expected %h", wd_at(0), {{8{8'hBF}}, {8{8'hFD}}});
        end
        cfg_avg = 0;
        run(ok, cyc);
        vectors++;
        if (!ok || wd_at(0) !== {{8{8'hFF}}, {8{8'hFE}}}) begin
            miscompares++;
            $display("FAIL neg_max: got %h expected %h", wd_at(0), {{8{8'hFF}}, {8{8'hFE}}});
        end
    endtask

    task automatic test_row_wrap();
        bit ok;
        int cyc;
        int a;
        logic [W-1:0] exp0, exp1;
        fill_ramp(0, 0);
        fill_ramp(1, 4);
        fill_ramp(2, 100);
        fill_ramp(3, 100);
        fill_ramp(8, 32);
        fill_ramp(9, 36);
        set_cfg(0, 1, 0, 0, 8, 2, 2, 'hFFFF);
        run(ok, cyc);
        for (int s = 0; s < 2; s++)
            for (int g = 0; g < 8; g++) begin
                a = s;
                exp0[(8*s+g)*DW +: DW] = DW'(4*a + 2*g + 1);
                a = 8 + s;
                exp1[(8*s+g)*DW +: DW] = DW'(4*a + 2*g + 1);
            end
        vectors++;
        if (!ok || cyc != 11) begin
            miscompares++;
            $display("FAIL wrap_latency: got done=%0b cyc=%0d expected 1 11", ok, cyc);
        end
        vectors++;
        if (rd_log.size() - rd0 != 4 ||
            {rd_at(0), rd_at(1), rd_at(2), rd_at(3)} !== {16'd0, 16'd1, 16'd8, 16'd9}) begin
            miscompares++;
            $display("FAIL wrap_raddr: got %h %h %h %h expected 0 1 8 9",
                     rd_at(0), rd_at(1), rd_at(2), rd_at(3));
        end
        vectors++;
        if (wa_log.size() - wa0 != 2 || {wa_at(0), wa_at(1)} !== {16'hFFFF, 16'h0000}) begin
            miscompares++;
            $display("FAIL wrap_waddr: got %h %h expected ffff 0000", wa_at(0), wa_at(1));
        end
        vectors++;
        if (wd_at(0) !== exp0 || wd_at(1) !== exp1) begin
            miscompares++;
            $display("FAIL wrap_data: got %h / %h expected %h / %h", wd_at(0), wd_at(1), exp0, exp1);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        int busy_bad;
        bit busy_at_done;
        set_cfg(0, 1, 0, 0, 8, 2, 2, 'h20);
        mark();
        busy_bad = 0;
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        cyc = 1;
        while (!done && cyc < 500) begin
            if (!busy) busy_bad++;
            start = (cyc == 3 || cyc == 7);
            if (cyc == 4) begin
                cfg_rd_base = 16'd40;
                cfg_num_out = 16'd5;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 0;
        busy_at_done = busy;
        vectors++;
        if (!done || busy_at_done !== 1'b0 || cyc != 11) begin
            miscompares++;
            $display("FAIL busy_done: got done=%b busy=%b cyc=%0d expected 1 0 11", done, busy_at_done, cyc);
        end
        vectors++;
        if (busy_bad != 0) begin
            miscompares++;
            $display("FAIL busy_held: got %0d low cycles expected 0", busy_bad);
        end
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (wa_log.size() - wa0 != 2 || {wa_at(0), wa_at(1)} !== {16'h0020, 16'h0021}) begin
            miscompares++;
            $display("FAIL busy_writes: got n=%0d %h %h expected 2 0020 0021",
                     wa_log.size() - wa0, wa_at(0), wa_at(1));
        end
        vectors++;
        if (rd_log.size() - rd0 != 4 ||
            {rd_at(0), rd_at(1), rd_at(2), rd_at(3)} !== {16'd0, 16'd1, 16'd8, 16'd9}) begin
            miscompares++;
            $display("FAIL busy_raddr: got %h %h %h %h expected 0 1 8 9",
                     rd_at(0), rd_at(1), rd_at(2), rd_at(3));
        end
        vectors++;
        if (done_cnt - dn0 != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_pulses: got done=%0d busy=%b expected 1 0", done_cnt - dn0, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        logic [W-1:0] exp_w;
        for (int w = 4; w < 8; w++) fill_ramp(w, 16 * (w - 4) - 64);
        set_cfg(0, 2, 0, 4, 4, 4, 1, 'h70);
        mark();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1 || rd_en !== 1'b0 || rd_log.size() - rd0 != 3) begin
            miscompares++;
            $display("FAIL rstmid_pre: got busy=%b rd_en=%b reads=%0d expected 1 0 3",
                     busy, rd_en, rd_log.size() - rd0);
        end
        reset = 0;
        #1;
        vectors++;
        if ({rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_async: got ctl=%b rd=%h wr=%h d=%h expected all 0",
                     {rd_en, wr_en, busy, done}, rd_addr, wr_addr, wr_data);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (wa_log.size() - wa0 != 0 || done_cnt - dn0 != 0) begin
            miscompares++;
            $display("FAIL rstmid_nowrite: got w=%0d d=%0d expected 0 0",
                     wa_log.size() - wa0, done_cnt - dn0);
        end
        @(negedge clk);
        reset = 1;
        run(ok, cyc);
        for (int s = 0; s < 4; s++)
            for (int g = 0; g < 4; g++)
                exp_w[(4*s+g)*DW +: DW] = DW'(16*s + 4*g + 3 - 64);
        vectors++;
        if (!ok || cyc != 10 ||
            {rd_at(0), rd_at(1), rd_at(2), rd_at(3)} !== {16'd4, 16'd5, 16'd6, 16'd7}) begin
            miscompares++;
            $display("FAIL rstmid_rerun: got done=%0b cyc=%0d rd=%h %h %h %h expected 1 10 4 5 6 7",
                     ok, cyc, rd_at(0), rd_at(1), rd_at(2), rd_at(3));
        end
        vectors++;
        if (wa_log.size() - wa0 != 1 || wa_at(0) !== 16'h0070 || wd_at(0) !== exp_w) begin
            miscompares++;
            $display("FAIL rstmid_data: got a=%h d=%h expected 0070 %h", wa_at(0), wd_at(0), exp_w);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rd0 = 0;
        wa0 = 0;
        dn0 = 0;
        test_reset();
        test_1d_max();
        test_2d_avg();
        test_negatives();
        test_row_wrap();
        test_start_while_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
